piso_serializer: RTL

- Parallel-in serial-out transmitter; the send-side counterpart to the team's serial-in shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per cycle on a valid/ready serial stream.
- Marks the final bit of each frame.
- Sits between a parallel producer (FIFO or register file) and a serial link or deserializer under test.

---
 rtl/piso_serializer.sv | 84 ++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter, valid/ready on both the word and bit sides.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the WIDTH data bits.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_p0, state_nxt;
  logic [CNT_W-1:0]     cnt_p0, cnt_nxt;
  logic [FRAME_LEN-1:0] sreg_p0, sreg_nxt;
  logic                 load, fire;

  // The parity bit sits at the tail of the frame, so it leaves after the last data bit.
  function automatic logic [FRAME_LEN-1:0] load_frame(input logic [WIDTH-1:0] w);
`ifdef SERIALIZER_PARITY_EN
    return MSB_FIRST ? {w, ^w} : {^w, w};
`else
    return w;
`endif
  endfunction

  function automatic logic [FRAME_LEN-1:0] shift_frame(input logic [FRAME_LEN-1:0] s);
    return MSB_FIRST ? {s[FRAME_LEN-2:0], 1'b0} : {1'b0, s[FRAME_LEN-1:1]};
  endfunction

  assign ser_valid = (state_p0 == SHIFT);
  assign ser_data  = MSB_FIRST ? sreg_p0[FRAME_LEN-1] : sreg_p0[0];
  assign ser_last  = ser_valid && (cnt_p0 == '0);
  assign fire      = ser_valid && ser_ready;
  // Ready also on the consumed last bit so consecutive frames run without a gap.
  assign in_ready  = !rst && ((state_p0 == IDLE) || (fire && ser_last));
  assign load      = in_valid && in_ready;

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    sreg_nxt  = sreg_p0;
    if (load) begin
      state_nxt = SHIFT;
      cnt_nxt   = CNT_W'(FRAME_LEN - 1);
      sreg_nxt  = load_frame(in_data);
    end else if (fire) begin
      sreg_nxt = shift_frame(sreg_p0);
      if (ser_last) begin
        state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt_p0 - CNT_W'(1);
      end
    end
  end

  // Stage p0: frame state, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      sreg_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      sreg_p0  <= sreg_nxt;
    end
  end

endmodule
